// File: rtl/qpsk_symbol_sync.sv
// qpsk_symbol_sync: bit-pair synchronizer between the serial-to-parallel
// splitter and the QPSK I/Q mapper. One holding buffer sits ahead of an
// active word. Each even/odd bit pair is held for HOLD enabled cycles.
// Optional feature macro: QPSK_SYNC_STATS_EN adds a saturating
// 16-bit underrun_count output.
//
// Handshake: a word pair is transferred on a rising edge where
// in_valid && in_ready. in_ready depends only on the buffer state, never on
// in_valid. The producer holds dataeve/dataodd stable while in_valid is high.
// in_valid may be dropped or raised on any cycle.
module qpsk_symbol_sync #(
    parameter int WIDTH     = 4,
    parameter int HOLD      = 52,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataeve,
    input  logic [WIDTH-1:0] dataodd,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             next1,
    input  logic             next2,
    output logic             even,
    output logic             odd,
    output logic             sym_strobe,
    output logic             busy,
    output logic             underrun,
`ifdef QPSK_SYNC_STATS_EN
    output logic [15:0]      underrun_count,
`endif
    output logic             o_dbg_state
);

    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] POS_FIRST = (LSB_FIRST != 0) ? '0 : IDX_LAST;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_full;
    logic [WIDTH-1:0] r_buf_eve;
    logic [WIDTH-1:0] r_buf_odd;
    logic [WIDTH-1:0] r_act_eve;
    logic [WIDTH-1:0] r_act_odd;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_even;
    logic             r_odd;
    logic             r_strobe;
    logic             r_underrun;

    logic             w_en;
    logic             w_accept;
    logic             w_bit_end;
    logic             w_last_bit;
    logic             w_end_word;
    logic             w_load;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] w_pos_cur;
    logic [IDX_W-1:0] w_pos_nxt;

    // Map the sending order (0 = first bit out) onto a word bit position.
    function automatic logic [IDX_W-1:0] pos_of(input logic [IDX_W-1:0] idx);
        return (LSB_FIRST != 0) ? idx : (IDX_LAST - idx);
    endfunction

    assign w_en       = next1 & next2;
    assign in_ready   = ~r_full & ~reset;
    assign w_accept   = in_valid & in_ready;
    assign w_bit_end  = (r_cnt == CNT_LAST);
    assign w_last_bit = (r_idx == IDX_LAST);
    assign w_end_word = w_en & (r_state == S_RUN) & w_bit_end & w_last_bit;
    // Buffer moves to the active register from IDLE, or seamlessly at word end.
    assign w_load     = w_en & r_full & ((r_state == S_IDLE) | (w_bit_end & w_last_bit));
    assign w_idx_nxt  = r_idx + IDX_W'(1);
    assign w_pos_cur  = pos_of(r_idx);
    assign w_pos_nxt  = pos_of(w_idx_nxt);

    // Holding buffer: filled by the handshake, emptied by a load (never both at once).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full    <= 1'b0;
            r_buf_eve <= '0;
            r_buf_odd <= '0;
        end else if (w_accept) begin
            r_full    <= 1'b1;
            r_buf_eve <= dataeve;
            r_buf_odd <= dataodd;
        end else if (w_load) begin
            r_full    <= 1'b0;
        end
    end

    // Serialiser FSM: hold counter, bit index and registered bit/strobe outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_act_eve  <= '0;
            r_act_odd  <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_even     <= 1'b0;
            r_odd      <= 1'b0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
            if (!w_en) begin
                // Stall: blank the outputs, everything else frozen.
                r_even <= 1'b0;
                r_odd  <= 1'b0;
            end else if (w_load) begin
                r_state   <= S_RUN;
                r_act_eve <= r_buf_eve;
                r_act_odd <= r_buf_odd;
                r_cnt     <= '0;
                r_idx     <= '0;
                r_even    <= r_buf_eve[POS_FIRST];
                r_odd     <= r_buf_odd[POS_FIRST];
                r_strobe  <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_even <= 1'b0;
                r_odd  <= 1'b0;
            end else if (!w_bit_end) begin
                // Mid-bit: re-present the current bit (also covers resume after a stall).
                r_cnt  <= r_cnt + CNT_W'(1);
                r_even <= r_act_eve[w_pos_cur];
                r_odd  <= r_act_odd[w_pos_cur];
            end else if (!w_last_bit) begin
                r_idx    <= w_idx_nxt;
                r_cnt    <= '0;
                r_even   <= r_act_eve[w_pos_nxt];
                r_odd    <= r_act_odd[w_pos_nxt];
                r_strobe <= 1'b1;
            end else begin
                // Word finished with nothing buffered.
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_idx      <= '0;
                r_even     <= 1'b0;
                r_odd      <= 1'b0;
                r_underrun <= 1'b1;
            end
        end
    end

`ifdef QPSK_SYNC_STATS_EN
    logic [15:0] r_underrun_count;

    // Saturating count of underrun events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_underrun_count <= '0;
        end else if (w_end_word && !r_full && (r_underrun_count != 16'hFFFF)) begin
            r_underrun_count <= r_underrun_count + 16'd1;
        end
    end

    assign underrun_count = r_underrun_count;
`endif

    assign even        = r_even;
    assign odd         = r_odd;
    assign sym_strobe  = r_strobe;
    assign underrun    = r_underrun;
    assign busy        = (r_state == S_RUN);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_qpsk_symbol_sync.sv
// tb_qpsk_symbol_sync: two instances (LSB-first and MSB-first, WIDTH=4,
// HOLD=4) share one set of inputs. A word-level model predicts every output
// each cycle; directed scenarios add hand-computed literal expectations.
module tb_qpsk_symbol_sync;

    localparam int WIDTH = 4;
    localparam int HOLD  = 4;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] dataeve;
    logic [WIDTH-1:0] dataodd;
    logic             in_valid;
    logic             next1;
    logic             next2;

    logic ready_l, even_l, odd_l, strobe_l, busy_l, under_l, dbg_l;
    logic ready_m, even_m, odd_m, strobe_m, busy_m, under_m, dbg_m;
`ifdef QPSK_SYNC_STATS_EN
    logic [15:0] ucnt_l;
    logic [15:0] ucnt_m;
`endif

    always #5 clk = ~clk;

    qpsk_symbol_sync #(.WIDTH(WIDTH), .HOLD(HOLD), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .reset(reset), .dataeve(dataeve), .dataodd(dataodd),
        .in_valid(in_valid), .in_ready(ready_l), .next1(next1), .next2(next2),
        .even(even_l), .odd(odd_l), .sym_strobe(strobe_l), .busy(busy_l),
        .underrun(under_l),
`ifdef QPSK_SYNC_STATS_EN
        .underrun_count(ucnt_l),
`endif
        .o_dbg_state(dbg_l)
    );

    qpsk_symbol_sync #(.WIDTH(WIDTH), .HOLD(HOLD), .LSB_FIRST(0)) u_msb (
        .clk(clk), .reset(reset), .dataeve(dataeve), .dataodd(dataodd),
        .in_valid(in_valid), .in_ready(ready_m), .next1(next1), .next2(next2),
        .even(even_m), .odd(odd_m), .sym_strobe(strobe_m), .busy(busy_m),
        .underrun(under_m),
`ifdef QPSK_SYNC_STATS_EN
        .underrun_count(ucnt_m),
`endif
        .o_dbg_state(dbg_m)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Words waiting in the holding buffer (at most one).
    logic [2*WIDTH-1:0] exp_q[$];
    bit               m_active = 1'b0;
    logic [WIDTH-1:0] m_weve   = '0;
    logic [WIDTH-1:0] m_wodd   = '0;
    int               m_slot   = 0;   // position in sending order
    int               m_left   = 0;   // enabled cycles left for this bit
    bit e_even_l = 0, e_odd_l = 0, e_even_m = 0, e_odd_m = 0;
    bit e_strobe = 0, e_under = 0, e_busy = 0;

    function automatic bit bit_of(input logic [WIDTH-1:0] w, input int slot, input bit lsb);
        return lsb ? w[slot] : w[WIDTH-1-slot];
    endfunction

    task automatic take_word();
        {m_weve, m_wodd} = exp_q.pop_front();
        m_active = 1'b1;
        m_slot   = 0;
        m_left   = HOLD;
        e_strobe = 1'b1;
    endtask

    task automatic model_step();
        bit en;
        bit acc;
        bit show;
        show     = 1'b0;
        e_strobe = 1'b0;
        e_under  = 1'b0;
        if (reset) begin
            exp_q.delete();
            m_active = 1'b0;
            m_slot   = 0;
            m_left   = 0;
        end else begin
            en  = next1 && next2;
            acc = in_valid && (exp_q.size() == 0);
            if (en) begin
                if (m_active) begin
                    m_left--;
                    if (m_left > 0) begin
                        show = 1'b1;
                    end else if (m_slot < WIDTH-1) begin
                        m_slot++;
                        m_left   = HOLD;
                        show     = 1'b1;
                        e_strobe = 1'b1;
                    end else if (exp_q.size() != 0) begin
                        take_word();
                        show = 1'b1;
                    end else begin
                        m_active = 1'b0;
                        e_under  = 1'b1;
                    end
                end else if (exp_q.size() != 0) begin
                    take_word();
                    show = 1'b1;
                end
            end
            if (acc) exp_q.push_back({dataeve, dataodd});
        end
        e_busy   = m_active;
        e_even_l = show && bit_of(m_weve, m_slot, 1'b1);
        e_odd_l  = show && bit_of(m_wodd, m_slot, 1'b1);
        e_even_m = show && bit_of(m_weve, m_slot, 1'b0);
        e_odd_m  = show && bit_of(m_wodd, m_slot, 1'b0);
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // ---------------- monitors for literal checks ----------------
    int               cyc = 0;
    int               mon_strobes, mon_unders, mon_busy, mon_zero;
    int               last_strobe, min_gap, max_gap;
    logic [WIDTH-1:0] cap_le, cap_lo, cap_me, cap_mo;

    task automatic clr_mon();
        mon_strobes = 0; mon_unders = 0; mon_busy = 0; mon_zero = 0;
        last_strobe = 0; min_gap = 1000; max_gap = 0;
        cap_le = '0; cap_lo = '0; cap_me = '0; cap_mo = '0;
    endtask

    // Compare process: every cycle, both DUTs against the model.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (chk_on) begin
            chk("even_lsb",   even_l,   e_even_l);
            chk("odd_lsb",    odd_l,    e_odd_l);
            chk("even_msb",   even_m,   e_even_m);
            chk("odd_msb",    odd_m,    e_odd_m);
            chk("strobe_lsb", strobe_l, e_strobe);
            chk("strobe_msb", strobe_m, e_strobe);
            chk("under_lsb",  under_l,  e_under);
            chk("under_msb",  under_m,  e_under);
            chk("busy_lsb",   busy_l,   e_busy);
            chk("busy_msb",   busy_m,   e_busy);
            chk("dbg_lsb",    dbg_l,    e_busy);
            chk("ready_lsb",  ready_l,  (exp_q.size() == 0) && !reset);
            chk("ready_msb",  ready_m,  (exp_q.size() == 0) && !reset);
        end
        if (busy_l) mon_busy++;
        if (busy_l && !even_l && !odd_l) mon_zero++;
        if (under_l) mon_unders++;
        if (strobe_l) begin
            cap_le[mon_strobes % WIDTH]           = even_l;
            cap_lo[mon_strobes % WIDTH]           = odd_l;
            cap_me[WIDTH-1 - (mon_strobes % WIDTH)] = even_m;
            cap_mo[WIDTH-1 - (mon_strobes % WIDTH)] = odd_m;
            if (mon_strobes > 0) begin
                if (cyc - last_strobe < min_gap) min_gap = cyc - last_strobe;
                if (cyc - last_strobe > max_gap) max_gap = cyc - last_strobe;
            end
            last_strobe = cyc;
            mon_strobes++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] o);
        int guard;
        guard    = 0;
        dataeve  = e;
        dataodd  = o;
        in_valid = 1'b1;
        while (!ready_l && guard < 200) begin
            tick();
            guard++;
        end
        chk("send_timeout", 16'(guard < 200), 16'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int guard;
        reset = 1'b1; in_valid = 1'b0; dataeve = '0; dataodd = '0;
        next1 = 1'b1; next2 = 1'b1;
        clr_mon();
        run(3);
        chk_on = 1'b1;
        chk("rst_even",  even_l,  0);
        chk("rst_odd",   odd_l,   0);
        chk("rst_busy",  busy_l,  0);
        chk("rst_ready", ready_l, 0);
        reset = 1'b0;
        #1;
        chk("rel_ready", ready_l, 1);
        tick();

        // Single word then underrun.
        clr_mon();
        send(4'b1010, 4'b0110);
        run(24);
        chk("t1_strobes", 16'(mon_strobes), 16'd4);
        chk("t1_unders",  16'(mon_unders),  16'd1);
        chk("t1_busy",    16'(mon_busy),    16'd16);
        chk("t1_cap_le",  cap_le, 4'b1010);
        chk("t1_cap_lo",  cap_lo, 4'b0110);
        chk("t1_cap_me",  cap_me, 4'b1010);
        chk("t1_idle",    busy_l, 0);

        // Back-to-back words, no gap.
        clr_mon();
        send(4'h3, 4'hC);
        send(4'hF, 4'h0);
        chk("t2_ready_low", ready_l, 0);
        run(40);
        chk("t2_strobes", 16'(mon_strobes), 16'd8);
        chk("t2_unders",  16'(mon_unders),  16'd1);
        chk("t2_busy",    16'(mon_busy),    16'd32);
        chk("t2_min_gap", 16'(min_gap),     16'd4);
        chk("t2_max_gap", 16'(max_gap),     16'd4);
        chk("t2_ready_hi", ready_l, 1);

        // Stall of 3 cycles inside bit 2.
        clr_mon();
        send(4'b1010, 4'b0110);
        guard = 0;
        while (mon_strobes < 3 && guard < 100) begin
            tick();
            guard++;
        end
        chk("t3_wait", 16'(guard < 100), 16'd1);
        next2 = 1'b0;
        run(3);
        next2 = 1'b1;
        run(25);
        chk("t3_strobes", 16'(mon_strobes), 16'd4);
        chk("t3_busy",    16'(mon_busy),    16'd19);
        chk("t3_zero",    16'(mon_zero),    16'd7);
        chk("t3_cap_le",  cap_le, 4'b1010);
        chk("t3_cap_lo",  cap_lo, 4'b0110);

        // Bit order: MSB-first instance must lead with bit 3.
        clr_mon();
        send(4'b1000, 4'b0001);
        run(24);
        chk("t4_cap_me", cap_me, 4'b1000);
        chk("t4_cap_mo", cap_mo, 4'b0001);
        chk("t4_cap_le", cap_le, 4'b1000);

        // Reset in the middle of a word.
        clr_mon();
        send(4'hF, 4'hF);
        run(6);
        chk("t5_pre_even", even_l, 1);
        reset = 1'b1;
        #1;
        chk("t5_even",  even_l,  0);
        chk("t5_odd",   odd_l,   0);
        chk("t5_busy",  busy_l,  0);
        chk("t5_ready", ready_l, 0);
        run(2);
        reset = 1'b0;
        #1;
        chk("t5_rel_ready", ready_l, 1);
        tick();
        clr_mon();
        send(4'b1100, 4'b0011);
        run(24);
        chk("t5_strobes", 16'(mon_strobes), 16'd4);
        chk("t5_busy",    16'(mon_busy),    16'd16);
        chk("t5_cap_le",  cap_le, 4'b1100);
        chk("t5_cap_lo",  cap_lo, 4'b0011);

`ifdef QPSK_SYNC_STATS_EN
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            send(4'h1, 4'h2);
            run(20);
        end
        chk("stats_three", ucnt_l, 16'd3);
        chk("stats_three_m", ucnt_m, 16'd3);
        reset = 1'b1;
        #1;
        chk("stats_clear", ucnt_l, 16'd0);
        run(2);
        reset = 1'b0;
        tick();
`endif

        run(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qpsk_symbol_sync.md
# qpsk_symbol_sync

Parametrised bit-pair synchronizer for the QPSK modulator. It accepts parallel even/odd (I/Q) words over a valid/ready handshake and buffers one word ahead. It serialises each word into one bit per branch, holding every bit for a fixed number of clock cycles. It sits between the serial-to-parallel splitter and the I/Q mapper, and produces a symbol strobe plus an underrun flag so that symbols are continuous and gap-free whenever upstream keeps pace.

## Interface
- WIDTH, 4: bits per input word on each branch; must be ≥1.
- HOLD, 52: clock cycles each bit is held on `even`/`odd`; must be ≥1.
- LSB_FIRST, 1: 1 sends bit 0 first; 0 sends bit WIDTH-1 first.
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- dataeve  in  WIDTH  even-branch word.
- dataodd  in  WIDTH  odd-branch word.
- in_valid  in  1  dataeve/dataodd pair is valid.
- in_ready  out  1  block can accept a word this cycle.
- next1, next2  in  1 each  downstream enables; the block runs only while both are 1.
- even  out  1  current even-branch bit, registered.
- odd  out  1  current odd-branch bit, registered.
- sym_strobe  out  1  1-cycle pulse in the first cycle a new bit pair is presented.
- busy  out  1  state is RUN.
- underrun  out  1  1-cycle pulse when a word finishes and no next word is buffered.

## Operation
- Storage: one holding buffer (word pair plus `full` flag) and one active shift register.
- in_ready = !full. A word is accepted when in_valid && in_ready; `full` sets on the accepting edge.
- States: IDLE and RUN.
  - IDLE: even=odd=0. If full && next1 && next2, move the buffer into the active register, clear full, go to RUN, present the first bit, pulse sym_strobe.
  - RUN: hold counter `cnt` counts 0..HOLD-1 while next1 && next2.
- End of a bit, when cnt==HOLD-1:
  - If it is not the last bit: advance to the next bit (order set by LSB_FIRST), set cnt=0, pulse sym_strobe.
  - If it is the last bit and full: load the buffer on the same edge with no gap, clear full, pulse sym_strobe.
  - If it is the last bit and not full: pulse underrun, go to IDLE, even=odd=0.
- Stall: when next1 && next2 is 0, even=odd=0. cnt, bit index and active word are frozen. On re-enable the same bit is re-presented with the remaining hold count; no sym_strobe is issued on resume.
- Accept during a load edge: in_ready was 1 only if the buffer was already empty, so a buffer load and a new accept never coincide.
- Widths: cnt is $clog2(HOLD) bits, minimum 1; bit index is $clog2(WIDTH) bits, minimum 1. Both wrap to 0 only through the explicit rules above.

## Timing
- Reset (asynchronous assertion) values: even=0, odd=0, sym_strobe=0, underrun=0, busy=0, full=0, cnt=0, index=0, state=IDLE.
- in_ready=0 while reset is asserted and 1 on the first cycle after release.
- Latency: word accepted at edge k → first bit on even/odd after edge k+1, if next1 && next2 at edge k+1.
- Each bit is visible for exactly HOLD enabled cycles. A word takes WIDTH×HOLD enabled cycles.
- Back-to-back: with the buffer refilled before the last bit ends, sym_strobe repeats every HOLD cycles indefinitely.
- Reset mid-word: the active and buffered words are discarded, and outputs are 0 asynchronously.

## Configuration
- QPSK_SYNC_STATS_EN defined:
  - Adds output `underrun_count` [15:0].
  - It increments on each underrun pulse and saturates at 16'hFFFF.
  - It clears on reset.
- QPSK_SYNC_STATS_EN undefined: the port and counter are absent. The underrun pulse is unchanged.

## Test plan
- WIDTH=4, HOLD=4, LSB_FIRST=1. Send dataeve=4'b1010 and dataodd=4'b0110 with next1=next2=1 → even 0,1,0,1 and odd 0,1,1,0, each held 4 cycles. sym_strobe fires 4 times, then one underrun pulse and busy falls.
- Same parameters; a second word (4'hF/4'h0) is offered while the first plays → no gap, sym_strobe period stays 4. in_ready drops once the buffer fills and reasserts after the buffer loads.
- Drop next2 for 3 cycles in the middle of bit 2 → even=odd=0 for those cycles. The bit resumes with its remaining count, and total word duration is 16+3 cycles.
- LSB_FIRST=0, dataeve=4'b1000 → even shows 1 first, then 0,0,0.
- Assert reset mid-word → all outputs 0 immediately and in_ready=1 after release. The next word starts cleanly from bit 0 with cnt=0.
- With QPSK_SYNC_STATS_EN: force 3 underruns → underrun_count=3. After reset, underrun_count=0.
